// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - multi-lane partial-sum accumulator with Q24.8 saturation and optional ReLU
module psum_acc #(
  parameter int LANES = 9,
  parameter int IW    = 24,
  parameter int FW    = 8,
  parameter int GW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*(IW+FW)-1:0] psum_i,
  input  logic                  psum_valid_i,
  input  logic                  psum_first_i,
  input  logic                  psum_last_i,
  output logic                  psum_ready_o,
  input  logic                  relu_en_i,
  output logic [LANES*(IW+FW)-1:0] acc_o,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic                  ovf_o,
  output logic                  err_o
);
  localparam int DW = IW + FW;
  localparam int AW = DW + GW;
  localparam int CW = 9;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [LANES-1:0][AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [LANES*DW-1:0]         acc_o_q, acc_o_d;
  logic                        acc_valid_q, acc_valid_d;
  logic                        ovf_q, ovf_d;
  logic                        err_q, err_d;

  logic                        beat_acc;
  logic                        load;
  logic [LANES-1:0][AW-1:0]    acc_nx;
  logic [LANES-1:0][DW-1:0]    lane_res;
  logic [LANES-1:0]            lane_sat;

  assign psum_ready_o = !acc_valid_q || acc_ready_i;
  assign acc_o        = acc_o_q;
  assign acc_valid_o  = acc_valid_q;
  assign ovf_o        = ovf_q;
  assign err_o        = err_q;

  always_comb begin
    beat_acc = psum_valid_i && psum_ready_o;
    load     = psum_first_i || (state_q == S_IDLE);
    acc_nx   = acc_q;
    lane_res = '0;
    lane_sat = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_nx[k] = load ? {{GW{psum_i[k*DW+DW-1]}}, psum_i[k*DW +: DW]}
                       : acc_q[k] + {{GW{psum_i[k*DW+DW-1]}}, psum_i[k*DW +: DW]};
      // In range only when the guard bits plus the word sign bit all agree
      lane_sat[k] = !((&acc_nx[k][AW-1:DW-1]) || !(|acc_nx[k][AW-1:DW-1]));
      if (lane_sat[k]) begin
        lane_res[k] = acc_nx[k][AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
        lane_res[k] = acc_nx[k][DW-1:0];
      end
      if (relu_en_i && lane_res[k][DW-1]) begin
        lane_res[k] = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_o_d     = acc_o_q;
    acc_valid_d = acc_valid_q;
    ovf_d       = ovf_q;
    err_d       = err_q;

    if (acc_valid_q && acc_ready_i) begin
      acc_valid_d = 1'b0;
    end

    if (beat_acc) begin
      acc_d   = acc_nx;
      state_d = psum_last_i ? S_IDLE : S_ACC;
      if ((state_q == S_IDLE && !psum_first_i) || (state_q == S_ACC && psum_first_i)) begin
        err_d = 1'b1;
      end
      if (load) begin
        cnt_d = {{(CW-1){1'b0}}, 1'b1};
      end else begin
        if (cnt_q[CW-1]) begin
          err_d = 1'b1;
        end
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      if (psum_last_i) begin
        acc_o_d     = lane_res;
        acc_valid_d = 1'b1;
        ovf_d       = |lane_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_o_q     <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_o_q     <= acc_o_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_psum_acc.sv
// tb/tb_psum_acc.sv - directed and randomized bench for psum_acc against an arithmetic reference model
module tb_psum_acc;
  localparam int LANES = 9;
  localparam int DW    = 32;
  localparam int VW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] psum_i;
  logic          psum_valid_i, psum_first_i, psum_last_i, relu_en_i, acc_ready_i;
  logic          psum_ready_o, acc_valid_o, ovf_o, err_o;
  logic [VW-1:0] acc_o;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  longint        m_acc [LANES];
  bit            m_open, m_valid, m_ovf, m_err;
  int            m_cnt;
  logic [VW-1:0] m_out;

  psum_acc dut (
    .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .psum_valid_i(psum_valid_i),
    .psum_first_i(psum_first_i), .psum_last_i(psum_last_i), .psum_ready_o(psum_ready_o),
    .relu_en_i(relu_en_i), .acc_o(acc_o), .acc_valid_o(acc_valid_o),
    .acc_ready_i(acc_ready_i), .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [VW-1:0] rnd_lanes();
    logic [VW-1:0] r;
    for (int k = 0; k < LANES; k++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: r[k*DW +: DW] = DW'($urandom_range(0, 4000)) - 32'd2000;
        3:       r[k*DW +: DW] = 32'($urandom);
        4:       r[k*DW +: DW] = 32'h7FFF_FFFF;
        default: r[k*DW +: DW] = 32'h8000_0000;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LANES; k++) m_acc[k] = 0;
    m_open = 0; m_valid = 0; m_ovf = 0; m_err = 0; m_cnt = 0; m_out = '0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, " acc_valid"}, VW'(acc_valid_o), VW'(m_valid));
    chk({tag, " acc_o"}, acc_o, m_out);
    chk({tag, " ovf"}, VW'(ovf_o), VW'(m_ovf));
    chk({tag, " err"}, VW'(err_o), VW'(m_err));
  endtask

  // One cycle: drive, predict acceptance from the model, advance clock, compare.
  task automatic beat(input bit v, input bit f, input bit l, input bit r, input bit ar,
                      input logic [VW-1:0] d, input string tag);
    bit     exp_ready, load;
    longint s;
    logic [DW-1:0] w;
    psum_valid_i = v; psum_first_i = f; psum_last_i = l; relu_en_i = r;
    acc_ready_i = ar; psum_i = d;
    #1;
    exp_ready = !m_valid || ar;
    chk({tag, " ready"}, VW'(psum_ready_o), VW'(exp_ready));
    if (m_valid && ar) m_valid = 0;
    if (v && exp_ready) begin
      load = f || !m_open;
      if (m_open == f) m_err = 1;
      if (load) m_cnt = 1;
      else begin
        if (m_cnt >= 256) m_err = 1;
        m_cnt++;
      end
      for (int k = 0; k < LANES; k++) begin
        w = d[k*DW +: DW];
        m_acc[k] = (load ? 0 : m_acc[k]) + longint'($signed(w));
      end
      m_open = !l;
      if (l) begin
        m_valid = 1;
        m_ovf = 0;
        for (int k = 0; k < LANES; k++) begin
          s = m_acc[k];
          if (s > 64'sd2147483647) begin s = 64'sd2147483647; m_ovf = 1; end
          if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_ovf = 1; end
          if (r && s < 0) s = 0;
          m_out[k*DW +: DW] = s[DW-1:0];
        end
      end
    end
    @(posedge clk); #1;
    chk_outputs(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, " rst ready"}, VW'(psum_ready_o), VW'(1'b1));
    chk_outputs({tag, " rst"});
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [VW-1:0] d;
    bit            f, l;
    rst_n = 1'b0; psum_i = '0; psum_valid_i = 0; psum_first_i = 0; psum_last_i = 0;
    relu_en_i = 0; acc_ready_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", VW'(psum_ready_o), VW'(1'b1));
    chk_outputs("reset");
    rst_n = 1'b1;

    // three beats of 1.0
    beat(1, 1, 0, 0, 1, fill(32'h100), "sum3 b0");
    beat(1, 0, 0, 0, 1, fill(32'h100), "sum3 b1");
    beat(1, 0, 1, 0, 1, fill(32'h100), "sum3 b2");
    chk("sum3 const", acc_o, fill(32'h300));
    beat(0, 0, 0, 0, 1, '0, "drain");

    // single first&&last with ReLU on and off
    d = rnd_lanes(); d[DW-1:0] = 32'hFFFF_FF00;
    beat(1, 1, 1, 1, 1, d, "relu on");
    chk("relu on lane0", VW'(acc_o[DW-1:0]), VW'(32'h0));
    beat(1, 1, 1, 0, 1, d, "relu off");
    chk("relu off lane0", VW'(acc_o[DW-1:0]), VW'(32'hFFFF_FF00));

    // positive and negative saturation
    beat(1, 1, 0, 0, 1, fill(32'h7FFF_FFFF), "satp b0");
    beat(1, 0, 1, 0, 1, fill(32'h7FFF_FFFF), "satp b1");
    chk("satp const", {acc_o, ovf_o} >> 0, {fill(32'h7FFF_FFFF), 1'b1} >> 0);
    beat(1, 1, 0, 0, 1, fill(32'h8000_0000), "satn b0");
    beat(1, 0, 1, 0, 1, fill(32'h8000_0000), "satn b1");

    // back-pressure: pending result held for 5 cycles, then back-to-back result
    beat(1, 1, 1, 0, 1, rnd_lanes(), "stall load");
    for (int i = 0; i < 5; i++) beat(1, 1, 0, 0, 0, rnd_lanes(), "stall hold");
    beat(1, 1, 1, 0, 1, rnd_lanes(), "b2b");
    chk("b2b valid", VW'(acc_valid_o), VW'(1'b1));
    beat(0, 0, 0, 0, 1, '0, "drain2");

    // protocol-correct random traffic
    for (int i = 0; i < 400; i++) begin
      f = !m_open;
      l = ($urandom_range(0, 3) == 0);
      beat($urandom_range(0, 3) != 0, f, l, $urandom_range(0, 1) != 0,
           $urandom_range(0, 2) != 0, rnd_lanes(), "rand");
    end

    // beat without first after reset
    pulse_reset("err1");
    beat(1, 0, 0, 0, 1, fill(32'h40), "nofirst b0");
    beat(1, 0, 1, 0, 1, fill(32'h40), "nofirst b1");

    // first mid-accumulation drops prior sums
    pulse_reset("err2");
    beat(1, 1, 0, 0, 1, fill(32'h1000), "refirst b0");
    beat(1, 1, 0, 0, 1, fill(32'h10), "refirst b1");
    beat(1, 0, 1, 0, 1, fill(32'h10), "refirst b2");
    chk("refirst const", acc_o, fill(32'h20));

    // 257-beat accumulation flags an error
    pulse_reset("err3");
    beat(1, 1, 0, 0, 1, fill(32'h1), "long b0");
    for (int i = 1; i < 256; i++) beat(1, 0, 0, 0, 1, fill(32'h1), "long");
    chk("long no err yet", VW'(err_o), VW'(1'b0));
    beat(1, 0, 1, 0, 1, fill(32'h1), "long b256");
    chk("long err", VW'(err_o), VW'(1'b1));

    // reset mid-accumulation, then a clean 2-beat sum
    pulse_reset("mid pre");
    beat(1, 1, 0, 0, 1, fill(32'h5555), "mid b0");
    pulse_reset("mid");
    beat(1, 1, 0, 0, 1, fill(32'h80), "post b0");
    beat(1, 0, 1, 0, 1, fill(32'h80), "post b1");
    chk("post const", acc_o, fill(32'h100));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/psum_acc.md
PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 Parameter LANES, default 9: number of partial-sum lanes per beat, matching the 3x3 PE output count.
REQ-002 Parameter IW, default 24: integer bits of Q format.
REQ-003 Parameter FW, default 8: fraction bits of Q format; word DW=IW+FW=32.
REQ-004 Parameter GW, default 8: accumulator guard bits; internal accumulator width AW=DW+GW=40.
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 psum_i  input  LANES*DW  partial sums, lane k at bits [k*DW +: DW], signed Q24.8.
REQ-009 psum_valid_i  input  1  beat present on psum_i.
REQ-010 psum_first_i  input  1  beat opens a new accumulation.
REQ-011 psum_last_i  input  1  beat closes the accumulation.
REQ-012 psum_ready_o  output  1  block accepts a beat this cycle.
REQ-013 relu_en_i  input  1  apply ReLU to result, sampled on last-beat acceptance.
REQ-014 acc_o  output  LANES*DW  final sums, same lane packing, signed Q24.8.
REQ-015 acc_valid_o  output  1  acc_o holds a result.
REQ-016 acc_ready_i  input  1  consumer takes acc_o.
REQ-017 ovf_o  output  1  qualified by acc_valid_o; at least one lane of acc_o saturated.
REQ-018 err_o  output  1  sticky protocol-error flag.

Function
REQ-019 Beat accepted iff psum_valid_i && psum_ready_o; psum_ready_o = !acc_valid_o || acc_ready_i (combinational).
REQ-020 States: IDLE (no open accumulation), ACC (open accumulation); IDLE->ACC on accepted beat without last; ACC->IDLE on accepted beat with last; first&&last beat keeps IDLE.
REQ-021 Each lane sign-extends its DW input to AW; first-marked beat, or any beat in IDLE, loads acc = sext(psum); otherwise acc = acc + sext(psum), AW-bit wrap-free for <=256 beats.
REQ-022 Beat counter increments per accepted beat and resets to 1 on a loading beat; the 257th beat of one accumulation sets err_o and the result is not guaranteed.
REQ-023 On accepted last beat, per lane: s = acc_next (including that beat); saturate s to [-2^31, 2^31-1]; if relu_en_i and result negative, output 0; register into acc_o next edge.
REQ-024 acc_valid_o rises the cycle after last-beat acceptance (latency 1); held with acc_o stable until acc_valid_o && acc_ready_i.
REQ-025 Completion and new last-beat acceptance in the same cycle: acc_o reloads, acc_valid_o stays 1, no bubble.
REQ-026 ovf_o = 1 iff any lane saturated (ReLU-zeroed lanes count if pre-ReLU saturation occurred); updates only with acc_o.
REQ-027 err_o set by: beat in IDLE without psum_first_i; psum_first_i beat in ACC (previous sums discarded, new accumulation starts); REQ-022 overflow; cleared only by reset.
REQ-028 Non-last beats in ACC are accepted only under REQ-019 (no accumulation while output stalls).

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, accumulators 0, counter 0, acc_o 0, acc_valid_o 0, ovf_o 0, err_o 0; psum_ready_o = 1 while reset is held and after release.
REQ-030 Reset mid-accumulation discards the open sums; the first beat after release is treated per REQ-021/REQ-027.

Verification
REQ-031 3 beats (first, -, last), all lanes 1.0 (0x100), relu_en_i=0 -> one cycle after last, acc_valid_o=1, every lane 0x300, ovf_o=0, err_o=0.
REQ-032 Single first&&last beat lane0=0xFFFFFF00 (-1.0), relu_en_i=1 -> lane0 0x00000000; relu_en_i=0 -> lane0 0xFFFFFF00.
REQ-033 2 beats each lane 0x7FFFFFFF -> lanes 0x7FFFFFFF, ovf_o=1; 2 beats 0x80000000 -> 0x80000000, ovf_o=1.
REQ-034 Result pending, acc_ready_i=0 for 5 cycles with psum_valid_i=1 -> psum_ready_o=0, acc_o stable; acc_ready_i=1 with a new last beat -> back-to-back result, acc_valid_o stays 1.
REQ-035 Beat without first after reset -> err_o=1 and sum starts from that beat; first beat mid-ACC -> err_o=1, prior sums dropped.
REQ-036 rst_n pulsed low mid-accumulation -> all outputs 0 immediately; next 2-beat first/last sequence of 0x80 yields 0x100.
